// File: rtl/syst_pkg.sv
// Shared definitions for the systolic-array feeder blocks.
package syst_pkg;

  // Default array geometry used by the feeder and its users.
  localparam int ROWS_DEF    = 4;
  localparam int X_WIDTH_DEF = 8;

  // Feeder control states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } feeder_state_t;

  // Gate a data word with its valid so that bubbles always carry zero.
  function automatic logic [63:0] gate_data(input logic vld, input logic [63:0] data);
    return vld ? data : 64'd0;
  endfunction

endpackage

// File: rtl/syst_delay_line.sv
// Registered valid+data shift chain of DEPTH stages. Data entering with
// valid low is forced to zero so every bubble travels as (0, 0).
module syst_delay_line
  import syst_pkg::*;
#(
  parameter int DEPTH = 1,
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic [DEPTH-1:0] vld_q;
  logic [WIDTH-1:0] dat_q [DEPTH];
  logic [WIDTH-1:0] data_in_gated;

  assign data_in_gated = WIDTH'(gate_data(valid_i, 64'(data_i)));

  // Shift valid and data one stage per clock; reset empties the chain.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= valid_i;
      dat_q[0] <= data_in_gated;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign valid_o = vld_q[DEPTH-1];
  assign data_o  = dat_q[DEPTH-1];

endmodule

// File: rtl/syst_skew_feeder.sv
// Skews activation vectors into a systolic array: row r sees each beat r
// cycles after row 0. After the last beat of a tile the feeder stops
// accepting input until the final element has left the bottom row.
module syst_skew_feeder
  import syst_pkg::*;
#(
  parameter int ROWS    = ROWS_DEF,
  parameter int X_WIDTH = X_WIDTH_DEF
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  input  logic [ROWS*X_WIDTH-1:0] s_data_i,
  input  logic                    s_last_i,
  output logic [ROWS*X_WIDTH-1:0] x_o,
  output logic [ROWS-1:0]         valid_o,
  output logic                    done_o
);

  localparam int CNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  feeder_state_t    state_q;
  feeder_state_t    state_d;
  logic [CNT_W-1:0] drain_cnt_q;
  logic             done_q;
  logic             beat;

  // Input is only blocked while the last tile drains down the skew.
  assign s_ready_o = (state_q != DRAIN);
  assign beat      = s_valid_i && s_ready_o;
  assign done_o    = done_q;

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (beat) begin
          state_d = s_last_i ? DRAIN : STREAM;
        end else begin
          state_d = IDLE;
        end
      end
      STREAM: begin
        if (beat && s_last_i) begin
          state_d = DRAIN;
        end else begin
          state_d = STREAM;
        end
      end
      DRAIN: begin
        if (done_q) begin
          state_d = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Count DRAIN cycles; done is registered one cycle ahead so it lines up
  // with the last element reaching row ROWS-1 (ROWS-1 cycles into DRAIN).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      drain_cnt_q <= '0;
      done_q      <= 1'b0;
    end else if (state_q == DRAIN) begin
      drain_cnt_q <= drain_cnt_q + 1'b1;
      done_q      <= (drain_cnt_q == CNT_W'(ROWS - 2));
    end else begin
      drain_cnt_q <= '0;
      done_q      <= 1'b0;
    end
  end

  // One delay line per row; row r is r+1 stages deep.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    syst_delay_line #(
      .DEPTH(r + 1),
      .WIDTH(X_WIDTH)
    ) u_delay (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .valid_i(beat),
      .data_i (s_data_i[r*X_WIDTH +: X_WIDTH]),
      .valid_o(valid_o[r]),
      .data_o (x_o[r*X_WIDTH +: X_WIDTH])
    );
  end

endmodule

// File: doc/syst_skew_feeder.md
SYST_SKEW_FEEDER -- requirements
Module: syst_skew_feeder

Interface
REQ-001 SHALL have parameter ROWS, default 4, meaning number of array rows fed (legal range 2..16).
REQ-002 SHALL have parameter X_WIDTH, default 8, meaning width of one activation element.
REQ-003 SHALL have port clk_i  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port s_valid_i  input  1  upstream vector valid.
REQ-006 SHALL have port s_ready_o  output  1  feeder can accept a vector this cycle.
REQ-007 SHALL have port s_data_i  input  ROWS*X_WIDTH  activation vector; row r occupies bits [r*X_WIDTH +: X_WIDTH].
REQ-008 SHALL have port s_last_i  input  1  marks the final vector of a tile; qualified by s_valid_i.
REQ-009 SHALL have port x_o  output  ROWS*X_WIDTH  skewed activations to the array row inputs, same row packing as s_data_i.
REQ-010 SHALL have port valid_o  output  ROWS  per-row valid; bit r drives row r node valid input.
REQ-011 SHALL have port done_o  output  1  one-cycle pulse when the last tile element leaves row ROWS-1.

Function
REQ-012 SHALL implement an FSM with states IDLE, STREAM, DRAIN.
REQ-013 SHALL accept a vector on a rising edge where s_valid_i and s_ready_o are both 1 (a "beat").
REQ-014 SHALL drive s_ready_o = 1 in IDLE and STREAM, 0 in DRAIN.
REQ-015 SHALL transition IDLE->STREAM on a beat with s_last_i=0; IDLE->DRAIN on a beat with s_last_i=1; STREAM->DRAIN on a beat with s_last_i=1; DRAIN->IDLE on the cycle done_o is 1.
REQ-016 SHALL present element r of a beat accepted at edge k on x_o row r with valid_o[r]=1 during the cycle following edge k+r (row 0 latency 1 cycle, row r latency r+1 cycles).
REQ-017 SHALL propagate a bubble (valid 0, data 0) through the skew for every cycle without a beat, so row r sees bubbles exactly r cycles after row 0.
REQ-018 SHALL drive x_o row r to 0 whenever valid_o[r]=0.
REQ-019 SHALL count DRAIN cycles with a counter of width clog2(ROWS); done_o SHALL assert in the cycle valid_o[ROWS-1] carries the last beat, i.e. ROWS-1 cycles after entering DRAIN.
REQ-020 SHALL allow a new tile beat in the cycle after done_o (IDLE accepts immediately).
REQ-021 SHALL ignore s_data_i and s_last_i when s_valid_i=0, and ignore s_valid_i while in DRAIN.
REQ-022 SHALL pass data unmodified (no arithmetic, no width change).

Reset
REQ-023 SHALL on rst_i force state IDLE, drain counter 0, all skew registers 0, valid_o=0, x_o=0, done_o=0, s_ready_o=1 after release.
REQ-024 SHALL on reset mid-tile discard all in-flight elements with no done_o pulse.

Structure
REQ-025 SHALL place the FSM state typedef (feeder_state_t) and the ROWS/X_WIDTH defaults in shared package syst_pkg.
REQ-026 SHALL instantiate sub-module syst_delay_line (parameters DEPTH, WIDTH; registered valid+data shift chain, async reset) once per row with DEPTH=r+1.

Verification (ROWS=4, X_WIDTH=8)
REQ-027 SHALL cover single-beat tile: beat {r3..r0}={04,03,02,01}, last=1 at edge 0 -> row0=01 cycle 1, row1=02 cycle 2, row2=03 cycle 3, row3=04 cycle 4 with done_o=1 in cycle 4, s_ready_o=0 cycles 1-4.
REQ-028 SHALL cover back-to-back 3-beat tile (beats A,B,C, last on C) -> each row shows A,B,C on consecutive cycles, row3 shows C in cycle 6, done_o exactly once.
REQ-029 SHALL cover bubble insertion: beat A, idle cycle, beat B(last) -> every row shows A, bubble (valid 0, x 0), B; row3 gap exactly 1 cycle.
REQ-030 SHALL cover DRAIN back-pressure: s_valid_i held 1 during DRAIN -> no beat accepted, no extra valid_o, first new beat accepted cycle after done_o.
REQ-031 SHALL cover reset mid-tile: assert rst_i two cycles after beat A -> valid_o=0, x_o=0 immediately, no done_o, IDLE after release.
REQ-032 SHALL cover array alignment: feeder driving a 4-row column of nodes with weights 1 -> column psumm equals sum of beat elements when row3 valid falls.
